// File: rtl/shift_normalizer_if.sv
// Start/done handshake bundle between the issuing control FSM and the normalizer.
interface shift_normalizer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] count;
  logic             zero;

  modport master (
    output start, data, mode,
    input  busy, done, result, count, zero
  );

  modport slave (
    input  start, data, mode,
    output busy, done, result, count, zero
  );
endinterface

// File: rtl/shift_normalizer.sv
// Bit-serial normalizer: counts leading (left mode) or trailing (right mode) zeros
// one bit per cycle and returns the aligned operand with the shift count.
module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_normalizer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;
  logic             r_zero;
  logic             w_zero_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_test_bit;

  assign w_test_bit = r_mode ? r_sreg[0] : r_sreg[WIDTH-1];

  // Next-state and datapath: a new request is accepted in IDLE or DONE
  always_comb begin
    w_state_nxt  = r_state;
    w_sreg_nxt   = r_sreg;
    w_mode_nxt   = r_mode;
    w_count_nxt  = r_count;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_sreg_nxt  = bus.data;
          w_mode_nxt  = bus.mode;
          w_count_nxt = {CNT_W{1'b0}};
          if (bus.data == {WIDTH{1'b0}}) begin
            w_zero_nxt   = 1'b1;
            w_count_nxt  = CNT_W'(WIDTH);
            w_result_nxt = {WIDTH{1'b0}};
            w_state_nxt  = ST_DONE;
          end else begin
            w_zero_nxt  = 1'b0;
            w_state_nxt = ST_SCAN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_test_bit) begin
          w_result_nxt = r_sreg;
          w_state_nxt  = ST_DONE;
        end else if (r_mode) begin
          w_sreg_nxt  = {1'b0, r_sreg[WIDTH-1:1]};
          w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_sreg_nxt  = {r_sreg[WIDTH-2:0], 1'b0};
          w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sreg   <= {WIDTH{1'b0}};
      r_mode   <= 1'b0;
      r_count  <= {CNT_W{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sreg   <= w_sreg_nxt;
      r_mode   <= w_mode_nxt;
      r_count  <= w_count_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_busy   <= (w_state_nxt == ST_SCAN);
      r_done   <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.count  = r_count;
  assign bus.zero   = r_zero;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed testbench for shift_normalizer: latency, alignment, handshake and reset cases.
module tb_shift_normalizer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  shift_normalizer_if #(.WIDTH(32)) bus ();

  shift_normalizer #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at a falling edge; it is accepted on the following rising edge.
  task automatic launch(input logic [31:0] d, input logic m);
    bus.start = 1'b1;
    bus.data  = d;
    bus.mode  = m;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Sample once per cycle until done; lat=1 means done in the cycle after acceptance.
  task automatic wait_done(output int lat, output int busy_n, output bit both, output bit tmo);
    lat = 1; busy_n = 0; both = 1'b0; tmo = 1'b0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (bus.busy === 1'b1 && bus.done === 1'b1) both = 1'b1;
    if (bus.done !== 1'b1) tmo = 1'b1;
  endtask

  task automatic test_reset;
    n_tests++;
    if ({bus.busy, bus.done, bus.zero, bus.count, bus.result} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b zero=%b count=%0d result=%h, expected all 0",
               bus.busy, bus.done, bus.zero, bus.count, bus.result);
    end
  endtask

  task automatic test_left;
    int lat, bn; bit both, tmo;
    launch(32'h0000_1000, 1'b0);
    wait_done(lat, bn, both, tmo);
    n_tests++; if (tmo) begin n_fail++; $display("FAIL left_timeout: done not seen in 100 cycles"); end
    n_tests++; if (bus.count !== 6'd19) begin n_fail++; $display("FAIL left_count: got %0d expected 19", bus.count); end
    n_tests++; if (bus.result !== 32'h8000_0000) begin n_fail++; $display("FAIL left_result: got %h expected 80000000", bus.result); end
    n_tests++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL left_zero: got %b expected 0", bus.zero); end
    n_tests++; if (lat !== 21) begin n_fail++; $display("FAIL left_latency: got %0d expected 21", lat); end
    n_tests++; if (bn !== 20) begin n_fail++; $display("FAIL left_busy_cycles: got %0d expected 20", bn); end
    n_tests++; if (both) begin n_fail++; $display("FAIL left_busy_and_done: got 1 expected 0"); end
    @(negedge clk);
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL left_done_pulse: got %b expected 0", bus.done); end
    n_tests++; if (bus.count !== 6'd19 || bus.result !== 32'h8000_0000) begin
      n_fail++; $display("FAIL left_hold: got count=%0d result=%h expected 19/80000000", bus.count, bus.result);
    end
  endtask

  task automatic test_right;
    int lat, bn; bit both, tmo;
    launch(32'h0000_1000, 1'b1);
    wait_done(lat, bn, both, tmo);
    n_tests++; if (tmo || bus.count !== 6'd12 || bus.result !== 32'h0000_0001 || bus.zero !== 1'b0) begin
      n_fail++; $display("FAIL right_1000: got count=%0d result=%h zero=%b expected 12/00000001/0", bus.count, bus.result, bus.zero);
    end
    n_tests++; if (lat !== 14) begin n_fail++; $display("FAIL right_1000_latency: got %0d expected 14", lat); end
    @(negedge clk);
    launch(32'h8000_0000, 1'b1);
    wait_done(lat, bn, both, tmo);
    n_tests++; if (tmo || bus.count !== 6'd31 || bus.result !== 32'h0000_0001) begin
      n_fail++; $display("FAIL right_worst: got count=%0d result=%h expected 31/00000001", bus.count, bus.result);
    end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL right_worst_latency: got %0d expected 33", lat); end
    @(negedge clk);
  endtask

  task automatic test_boundary;
    int lat, bn; bit both, tmo;
    for (int m = 0; m < 2; m++) begin
      launch(32'h0000_0000, m[0]);
      wait_done(lat, bn, both, tmo);
      n_tests++; if (tmo || bus.zero !== 1'b1 || bus.count !== 6'd32 || bus.result !== 32'h0) begin
        n_fail++; $display("FAIL zero_mode%0d: got zero=%b count=%0d result=%h expected 1/32/00000000", m, bus.zero, bus.count, bus.result);
      end
      n_tests++; if (lat !== 1 || bn !== 0) begin
        n_fail++; $display("FAIL zero_mode%0d_timing: got lat=%0d busy=%0d expected 1/0", m, lat, bn);
      end
      @(negedge clk);
    end
    launch(32'hFFFF_FFFF, 1'b0);
    wait_done(lat, bn, both, tmo);
    n_tests++; if (tmo || bus.count !== 6'd0 || bus.result !== 32'hFFFF_FFFF || bus.zero !== 1'b0) begin
      n_fail++; $display("FAIL ones_left: got count=%0d result=%h zero=%b expected 0/ffffffff/0", bus.count, bus.result, bus.zero);
    end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL ones_left_latency: got %0d expected 2", lat); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy;
    int lat, bn; bit both, tmo;
    launch(32'h0000_0001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.start = 1'b1;
      bus.data  = 32'h8000_0000;
      bus.mode  = ~bus.mode;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy_state: got busy=%b expected 1", bus.busy); end
    wait_done(lat, bn, both, tmo);
    n_tests++; if (tmo || bus.count !== 6'd31 || bus.result !== 32'h8000_0000) begin
      n_fail++; $display("FAIL ignore_result: got count=%0d result=%h expected 31/80000000", bus.count, bus.result);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, bn; bit both, tmo;
    launch(32'h0000_1000, 1'b1);
    wait_done(lat, bn, both, tmo);
    n_tests++; if (tmo || bus.count !== 6'd12) begin n_fail++; $display("FAIL b2b_first: got count=%0d expected 12", bus.count); end
    launch(32'h0000_00F0, 1'b1);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle: got busy=%b expected 1", bus.busy); end
    wait_done(lat, bn, both, tmo);
    n_tests++; if (tmo || bus.count !== 6'd4 || bus.result !== 32'h0000_000F) begin
      n_fail++; $display("FAIL b2b_second: got count=%0d result=%h expected 4/0000000f", bus.count, bus.result);
    end
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 6", lat); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int lat, bn, guard; bit both, tmo;
    launch(32'h0000_0001, 1'b0);
    guard = 0;
    while (bus.count !== 6'd7 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_tests++; if (bus.count !== 6'd7) begin n_fail++; $display("FAIL midreset_reach7: got %0d expected 7", bus.count); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({bus.busy, bus.done, bus.zero, bus.count, bus.result} !== 39'd0) begin
      n_fail++; $display("FAIL midreset_async: got busy=%b done=%b count=%0d result=%h expected all 0",
                         bus.busy, bus.done, bus.count, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    launch(32'h0100_0000, 1'b0);
    wait_done(lat, bn, both, tmo);
    n_tests++; if (tmo || bus.count !== 6'd7 || bus.result !== 32'h8000_0000) begin
      n_fail++; $display("FAIL midreset_after: got count=%0d result=%h expected 7/80000000", bus.count, bus.result);
    end
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL midreset_after_latency: got %0d expected 9", lat); end
    @(negedge clk);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.data  = 32'h0;
    bus.mode  = 1'b0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_left();
    test_right();
    test_boundary();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Multi-cycle normalizer for the execution datapath. Performs the inverse of the barrel shifter: given a 32-bit operand, it finds the shift amount that aligns the operand.
- Left mode counts leading zeros and left-aligns the operand. Right mode counts trailing zeros and right-aligns it.
- Scans one bit per cycle. Uses a start/done handshake toward the issuing control FSM.
- The resulting count feeds CLZ/CTZ-style results and normalization sequences that drive the barrel shifter's shamt.

Parameters:
- WIDTH, 32, operand width in bits; must be a power of two ≥ 4.
- CNT_W, $clog2(WIDTH)+1 (6), width of the count output; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- data  input  WIDTH  operand, captured on an accepted start.
- mode  input  1  0 = left (CLZ, left-align), 1 = right (CTZ, right-align); captured on an accepted start.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse; result, count and zero are valid from this cycle.
- result  output  WIDTH  aligned operand.
- count  output  CNT_W  number of single-bit shifts performed; WIDTH when the operand is zero.
- zero  output  1  operand was all zeros.

Behaviour:
- Reset (rst_n=0, any time, including mid-scan):
  - Goes to IDLE immediately.
  - busy=0, done=0, result=0, count=0, zero=0, internal shift register=0.
  - After release, the first accepted start behaves normally.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 → capture data into shift register, capture mode, count←0.
  - If data==0: zero←1, count←WIDTH, result←0, go to DONE.
  - Otherwise: zero←0, go to SCAN.
  - start=0 → stay; outputs hold their last values.
- SCAN (busy=1):
  - Test bit: MSB of the shift register in left mode, LSB in right mode.
  - Test bit = 1: result←shift register, go to DONE.
  - Test bit = 0:
    - Left mode: shift register ← shift register << 1.
    - Right mode: shift register ← shift register >> 1, logical, zero fill.
    - count←count+1.
  - start and data are ignored in SCAN.
  - count never exceeds WIDTH-1 here, because the operand is non-zero. No wrap is possible.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE, allowing back-to-back operations: the next state is SCAN, or DONE for a zero operand.
  - Otherwise go to IDLE.
- Latency, with start sampled high at the end of cycle C:
  - Zero operand: done high in C+1.
  - Non-zero operand with final count k: SCAN occupies cycles C+1..C+k+1 and done is high in C+k+2.
  - Worst case is k=WIDTH-1, i.e. done in C+WIDTH+1.
- Output stability: result, count and zero change only when leaving SCAN or on an accepted start. They hold until the next accepted start or reset.
- Intermediate counts during SCAN are visible on count; consumers use count only when done=1.
- The captured mode is fixed for the whole operation. Changes on the mode input after acceptance have no effect.
- busy and done are never high in the same cycle.

Test Plan:
- Left mode, data=0x0000_1000 → count=19, result=0x8000_0000, zero=0. busy high for 20 cycles; done one cycle later (C+21); done high for exactly 1 cycle.
- Right mode, data=0x0000_1000 → count=12, result=0x0000_0001, zero=0, done in C+14. Right mode, data=0x8000_0000 → count=31, result=0x0000_0001, done in C+33 (worst case).
- data=0x0000_0000 in each mode → zero=1, count=32, result=0, done in C+1, busy never asserted. Left mode, data=0xFFFF_FFFF → count=0, result=0xFFFF_FFFF, done in C+2.
- While busy on left data=0x0000_0001, drive start=1 with data=0x8000_0000 and toggle mode → request ignored; final count=31, result=0x8000_0000.
- Back-to-back: hold start=1 with new data=0x0000_00F0, right mode, during the DONE cycle of the previous op → second op accepted with no IDLE cycle; count=4, result=0x0000_000F.
- Assert rst_n=0 for one cycle mid-scan at count=7 → all outputs 0 and IDLE asynchronously. A subsequent left op on 0x0100_0000 gives count=7, result=0x8000_0000.
